// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: accept, execute, respond.
// Optional macro ALU_ARBITER_RR_EN selects round-robin contention; default is fixed priority to requester 0.
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [5:0]       req0_op,
  input  logic [5:0]       req1_op,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  output logic [5:0]       alu_op,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zr,
  output logic             rsp_ng
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [5:0]       op_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic             id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_zr_q, rsp_ng_q;

  logic accept;
  logic grant_id;

  // Ready is never offered while reset is asserted, so no requester sees an accept that reset discards.
  assign accept = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);

`ifdef ALU_ARBITER_RR_EN
  logic last_q;

  // Requester 1 wins contention only when requester 0 was granted last.
  assign grant_id = req1_valid && (!req0_valid || (last_q == 1'b0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant_id;
    end
  end
`else
  assign grant_id = req1_valid && !req0_valid;
`endif

  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: datapath registers are reset too, because the operand and response outputs must read 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_zr_q   <= 1'b0;
      rsp_ng_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q <= grant_id;
        op_q <= grant_id ? req1_op : req0_op;
        x_q  <= grant_id ? req1_x  : req0_x;
        y_q  <= grant_id ? req1_y  : req0_y;
      end
      if (state_q == EXEC) begin
        rsp_data_q <= alu_out;
        rsp_zr_q   <= alu_zr;
        rsp_ng_q   <= alu_ng;
      end
    end
  end

  assign alu_op    = op_q;
  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zr    = rsp_zr_q;
  assign rsp_ng    = rsp_ng_q;

endmodule
